ifetch_unit: RTL and testbench

- Instruction-fetch sequencer for the multicycle CPU datapath. It consumes the PC register's output and reads the instruction word from instruction memory over a req/ack handshake.
- It latches the word into the instruction register (IR) and drives the PC register's write strobe and next-PC value: PC+4 on normal fetch, redirect target on branch/jump.
- It sits between the control FSM (IF state), the PC register and imem.

---
 rtl/ifetch_unit.sv | 117 +++++++++++
 tb/tb_ifetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch sequencer: reads one word from imem over req/ack, latches it
// into IR and strobes the PC register with PC+4 or a redirect target.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic [31:0] pc_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        pc_we,
    output logic [31:0] pc_next,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, REQ, UPDATE} state_t;

    state_t      state, state_nx;
    logic [7:0]  wait_cnt, wait_cnt_nx;
    logic        req_nx, ir_valid_nx, pc_we_nx, err_nx;
    logic [31:0] addr_nx, ir_nx, pc_next_nx;
    logic        aligned, timeout_hit;

    assign aligned     = (pc_in[1:0] == 2'b00);
    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            ir        <= '0;
            ir_valid  <= 1'b0;
            pc_we     <= 1'b0;
            pc_next   <= RESET_PC;
            busy      <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_cnt_nx;
            imem_req  <= req_nx;
            imem_addr <= addr_nx;
            ir        <= ir_nx;
            ir_valid  <= ir_valid_nx;
            pc_we     <= pc_we_nx;
            pc_next   <= pc_next_nx;
            busy      <= (state_nx != IDLE);
            fetch_err <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!redirect_valid && fetch_start && aligned) state_nx = REQ;
            REQ:     if (imem_ack) state_nx = UPDATE;
                     else if (timeout_hit) state_nx = IDLE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are computed one cycle early so every port comes straight from a flop;
    // the ir_valid/pc_we pulses are therefore set on the ack edge and land in UPDATE.
    always_comb begin
        req_nx      = imem_req;
        addr_nx     = imem_addr;
        ir_nx       = ir;
        pc_next_nx  = pc_next;
        ir_valid_nx = 1'b0;
        pc_we_nx    = 1'b0;
        err_nx      = fetch_err;
        wait_cnt_nx = wait_cnt;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    pc_we_nx   = 1'b1;
                    pc_next_nx = redirect_addr;
                end else if (fetch_start) begin
                    err_nx = !aligned;
                    if (aligned) begin
                        addr_nx     = pc_in;
                        req_nx      = 1'b1;
                        wait_cnt_nx = '0;
                    end
                end
            end
            REQ: begin
                if (imem_ack) begin
                    ir_nx       = imem_rdata;
                    req_nx      = 1'b0;
                    ir_valid_nx = 1'b1;
                    pc_we_nx    = 1'b1;
                    pc_next_nx  = imem_addr + 32'd4;
                end else if (timeout_hit) begin
                    req_nx      = 1'b0;
                    err_nx      = 1'b1;
                    wait_cnt_nx = '0;
                end else begin
                    wait_cnt_nx = wait_cnt + 8'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: drivers push expected PC-register writes into a
// scoreboard queue, a negedge monitor pops and compares whenever pc_we fires.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          TMO    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic [31:0] pc_in = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        ir_valid;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        busy;
    logic        fetch_err;

    ifetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_in(pc_in),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid), .pc_we(pc_we),
        .pc_next(pc_next), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fetch;
        logic [31:0] pcn;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] prev_ir = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every PC write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ir = '0;
        end else begin
            if (pc_we) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pc_we: got pc_next %h expected no write at %0t", pc_next, $time);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc_next", pc_next, e.pcn);
                    chk("sb_ir_valid", {31'd0, ir_valid}, {31'd0, e.is_fetch});
                    if (e.is_fetch) chk("sb_ir", ir, e.instr);
                end
            end else if (ir_valid) begin
                chk("ir_valid_without_pc_we", {31'd0, ir_valid}, 32'd0);
            end
            if (!ir_valid) chk("ir_hold", ir, prev_ir);
            prev_ir = ir;
        end
    end

    // waits >= TMO models an imem that never answers.
    task automatic do_fetch(input logic [31:0] pc, input int waits, input logic [31:0] rdata);
        step();
        pc_in = pc; fetch_start = 1'b1; redirect_valid = 1'b0;
        step();
        fetch_start = 1'b0;
        if (pc[1:0] != 2'b00) begin
            chk("misalign_req", {31'd0, imem_req}, 32'd0);
            chk("misalign_err", {31'd0, fetch_err}, 32'd1);
            chk("misalign_busy", {31'd0, busy}, 32'd0);
            return;
        end
        chk("start_clears_err", {31'd0, fetch_err}, 32'd0);
        if (waits < TMO) sb.push_back('{1'b1, pc + 32'd4, rdata});
        for (int k = 0; k < TMO; k++) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, pc);
            chk("busy_req", {31'd0, busy}, 32'd1);
            pc_in          = $urandom;
            fetch_start    = 1'($urandom % 2);
            redirect_valid = 1'($urandom % 2);
            redirect_addr  = $urandom;
            if (k == waits) begin
                imem_ack = 1'b1; imem_rdata = rdata;
            end else begin
                imem_ack = 1'($urandom % 4 == 0) & 1'b0; imem_rdata = $urandom;
            end
            step();
            if (k == waits) break;
        end
        fetch_start = 1'b0; imem_ack = 1'b0; imem_rdata = $urandom;
        if (waits < TMO) begin
            chk("latency_pc_we", {31'd0, pc_we}, 32'd1);
            chk("latency_ir_valid", {31'd0, ir_valid}, 32'd1);
            redirect_valid = 1'($urandom % 2);
            redirect_addr  = $urandom;
            imem_ack       = 1'($urandom % 2);
            step();
            redirect_valid = 1'b0; imem_ack = 1'b0;
            chk("pc_we_one_cycle", {31'd0, pc_we}, 32'd0);
            chk("idle_after_update", {31'd0, busy}, 32'd0);
            chk("req_low_after_ack", {31'd0, imem_req}, 32'd0);
        end else begin
            redirect_valid = 1'b0;
            chk("timeout_req_drop", {31'd0, imem_req}, 32'd0);
            chk("timeout_err", {31'd0, fetch_err}, 32'd1);
            chk("timeout_busy", {31'd0, busy}, 32'd0);
            chk("timeout_no_pc_we", {31'd0, pc_we}, 32'd0);
        end
    endtask

    task automatic do_redirect(input logic [31:0] addr, input logic with_start, input logic [31:0] spc);
        step();
        redirect_valid = 1'b1; redirect_addr = addr; fetch_start = with_start; pc_in = spc;
        sb.push_back('{1'b0, addr, 32'd0});
        step();
        redirect_valid = 1'b0; fetch_start = 1'b0;
        chk("redirect_pc_we", {31'd0, pc_we}, 32'd1);
        chk("redirect_no_req", {31'd0, imem_req}, 32'd0);
        chk("redirect_busy", {31'd0, busy}, 32'd0);
        step();
        chk("redirect_pc_we_drop", {31'd0, pc_we}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("rst_pc_next", pc_next, RST_PC);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_ir", ir, 32'd0);
        chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

        do_fetch(32'h0000_3000, 0, 32'h2008_0005);
        do_fetch(32'h0000_3004, 3, 32'h8C09_0000);
        do_fetch(32'h0000_3008, TMO, 32'h0);
        do_fetch(32'h0000_300C, 0, 32'h1234_5678);
        do_fetch(32'h0000_3002, 0, 32'h0);
        do_redirect(32'h0000_3040, 1'b1, 32'h0000_3000);
        do_fetch(32'hFFFF_FFFC, 1, 32'hCAFE_F00D);

        // Asynchronous reset while a request is outstanding.
        step();
        pc_in = 32'h0000_3100; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_addr", imem_addr, RST_PC);
        chk("async_rst_pc_next", pc_next, RST_PC);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        do_fetch(32'h0000_3100, 1, 32'hA5A5_0001);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 11);
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC;
            if (r == 0)      do_redirect($urandom, 1'($urandom % 2), a);
            else if (r == 1) do_fetch(a | 32'($urandom_range(1, 3)), 0, 32'h0);
            else if (r == 2) do_fetch(a, TMO + $urandom_range(0, 3), 32'h0);
            else             do_fetch(a, $urandom_range(0, 6), $urandom);
        end

        repeat (3) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
